// File: rtl/ibex_mem_responder.sv
// ibex_mem_responder
// Memory-side responder for the core's instruction and data req/gnt/rvalid
// ports. Both ports share one single-port RAM with 1-cycle read latency;
// a round-robin arbiter picks at most one port per cycle and the response
// (data or bus error) is routed back to the granted port one cycle later.
module ibex_mem_responder #(
  parameter int unsigned MemSize  = 65536,
  parameter logic [31:0] BaseAddr = 32'h0000_0000,
  parameter int unsigned GntDelay = 0,
  localparam int unsigned AW = $clog2(MemSize / 32'd4)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          instr_req_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,
  input  logic          data_req_i,
  input  logic          data_we_i,
  input  logic [3:0]    data_be_i,
  input  logic [31:0]   data_addr_i,
  input  logic [31:0]   data_wdata_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic [31:0]   data_rdata_o,
  output logic          data_err_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic          mem_rvalid_i,
  input  logic [31:0]   mem_rdata_i
);

  localparam logic [3:0]  GNT_DELAY = 4'(GntDelay);
  localparam logic [32:0] MEM_SIZE  = 33'(MemSize);

  // Pending response: who owns it, whether it is an error, whether it
  // carries read data (loads and fetches) or not (stores).
  typedef struct packed {
    logic owner_data;
    logic err;
    logic load;
  } resp_t;

  logic [3:0]  wait_cnt_r;
  logic        last_data_r;
  logic        resp_valid_r;
  resp_t       resp_r;

  logic        gnt_instr_s;
  logic        gnt_data_s;
  logic        any_gnt_s;
  logic [31:0] win_addr_s;
  logic        win_we_s;
  logic [3:0]  win_be_s;
  logic [31:0] win_wdata_s;
  logic [31:0] win_off_s;
  logic        win_in_range_s;
  logic        mem_req_s;
  logic        rdata_ok_s;
  logic [31:0] resp_rdata_s;

  // Grant arbitration: wait out the delay, then the single requester or the
  // port not granted last wins. Grants are suppressed while in reset.
  always_comb begin
    gnt_instr_s = 1'b0;
    gnt_data_s  = 1'b0;
    if (rst_i) begin
      gnt_instr_s = 1'b0;
      gnt_data_s  = 1'b0;
    end else if (wait_cnt_r == GNT_DELAY) begin
      if (instr_req_i && (!data_req_i || last_data_r)) begin
        gnt_instr_s = 1'b1;
      end else if (data_req_i) begin
        gnt_data_s = 1'b1;
      end else begin
        gnt_instr_s = 1'b0;
        gnt_data_s  = 1'b0;
      end
    end else begin
      gnt_instr_s = 1'b0;
      gnt_data_s  = 1'b0;
    end
  end

  assign any_gnt_s   = gnt_instr_s | gnt_data_s;
  assign instr_gnt_o = gnt_instr_s;
  assign data_gnt_o  = gnt_data_s;

  // Winner access selection and address decode; fetches are full-word reads.
  always_comb begin
    win_addr_s  = instr_addr_i;
    win_we_s    = 1'b0;
    win_be_s    = 4'hF;
    win_wdata_s = 32'h0000_0000;
    if (gnt_data_s) begin
      win_addr_s  = data_addr_i;
      win_we_s    = data_we_i;
      win_be_s    = data_be_i;
      win_wdata_s = data_wdata_i;
    end else begin
      win_addr_s  = instr_addr_i;
      win_we_s    = 1'b0;
      win_be_s    = 4'hF;
      win_wdata_s = 32'h0000_0000;
    end
    win_off_s      = win_addr_s - BaseAddr;
    win_in_range_s = ({1'b0, win_off_s} < MEM_SIZE);
  end

  assign mem_req_s   = any_gnt_s & win_in_range_s;
  assign mem_req_o   = mem_req_s;
  assign mem_we_o    = mem_req_s & win_we_s;
  assign mem_be_o    = mem_req_s ? win_be_s : 4'h0;
  assign mem_addr_o  = mem_req_s ? win_off_s[AW+1:2] : {AW{1'b0}};
  assign mem_wdata_o = mem_req_s ? win_wdata_s : 32'h0000_0000;

  // Wait counter: counts stalled request cycles, restarts on every grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_r <= 4'd0;
    end else if (any_gnt_s) begin
      wait_cnt_r <= 4'd0;
    end else if (instr_req_i || data_req_i) begin
      wait_cnt_r <= wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Round-robin pointer: remembers which port was granted last.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_data_r <= 1'b1;
    end else if (any_gnt_s) begin
      last_data_r <= gnt_data_s;
    end else begin
      last_data_r <= last_data_r;
    end
  end

  // Pending response register: one entry, rewritten every cycle so that
  // back-to-back grants each get their own response slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_valid_r <= 1'b0;
      resp_r       <= '0;
    end else if (any_gnt_s) begin
      resp_valid_r      <= 1'b1;
      resp_r.owner_data <= gnt_data_s;
      resp_r.err        <= ~win_in_range_s;
      resp_r.load       <= ~win_we_s;
    end else begin
      resp_valid_r <= 1'b0;
      resp_r       <= '0;
    end
  end

  // Read data only passes when a real in-range read is pending and the RAM
  // answers; stray RAM responses are ignored.
  assign rdata_ok_s   = resp_valid_r & ~resp_r.err & resp_r.load & mem_rvalid_i;
  assign resp_rdata_s = rdata_ok_s ? mem_rdata_i : 32'h0000_0000;

  assign instr_rvalid_o = resp_valid_r & ~resp_r.owner_data;
  assign instr_err_o    = instr_rvalid_o & resp_r.err;
  assign instr_rdata_o  = resp_r.owner_data ? 32'h0000_0000 : resp_rdata_s;

  assign data_rvalid_o  = resp_valid_r & resp_r.owner_data;
  assign data_err_o     = data_rvalid_o & resp_r.err;
  assign data_rdata_o   = resp_r.owner_data ? resp_rdata_s : 32'h0000_0000;

endmodule
